// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU systolic array processing elements.
package npu_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_CNT_W  = 16;
    localparam int unsigned SAT_CALC_W     = 64;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } pe_state_t;

    // Clamp a wide signed value into the signed range of a data_w-bit word.
    function automatic logic signed [SAT_CALC_W-1:0] sat_to_data_w(
        input logic signed [SAT_CALC_W-1:0] value,
        input int unsigned                  data_w
    );
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        hi = (SAT_CALC_W'(64'sd1) <<< (data_w - 1)) - SAT_CALC_W'(64'sd1);
        lo = -(SAT_CALC_W'(64'sd1) <<< (data_w - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/mac.sv
// Signed multiply-add: result = act * weight + psum, wrapped to DATA_W bits.
module mac
    import npu_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] psum,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] act_ext;
    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] psum_ext;
    logic signed [PROD_W-1:0] prod;

    assign act_ext    = PROD_W'($signed(act));
    assign weight_ext = PROD_W'($signed(weight));
    assign psum_ext   = PROD_W'($signed(psum));
    assign prod       = act_ext * weight_ext;
    assign result     = DATA_W'(prod + psum_ext);

endmodule

// File: rtl/systolic_pe.sv
// Weight-stationary systolic PE: holds one weight, forwards activations east and sums south.
// Define PE_SAT_EN to saturate the MAC result instead of wrapping it.
module systolic_pe
    import npu_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              weight_shift,
    input  logic              weight_clr,
    output logic [DATA_W-1:0] weight_out,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_valid_in,
    input  logic [DATA_W-1:0] psum_in,
    output logic [DATA_W-1:0] act_out,
    output logic              act_valid_out,
    output logic [DATA_W-1:0] psum_out,
    output logic              psum_valid_out,
    output logic              weight_loaded,
    output logic              err_no_weight,
    output logic [CNT_W-1:0]  mac_count
);

    pe_state_t         state;
    logic [DATA_W-1:0] mac_result;

`ifdef PE_SAT_EN
    localparam int unsigned WIDE_W = 2 * DATA_W + 1;

    logic signed [WIDE_W-1:0] wide_sum;

    assign wide_sum   = WIDE_W'($signed(act_in)) * WIDE_W'($signed(weight_out))
                      + WIDE_W'($signed(psum_in));
    assign mac_result = DATA_W'(sat_to_data_w(SAT_CALC_W'(wide_sum), DATA_W));
`else
    mac #(
        .DATA_W (DATA_W)
    ) u_mac (
        .act    (act_in),
        .weight (weight_out),
        .psum   (psum_in),
        .result (mac_result)
    );
`endif

    assign weight_loaded = (state == LOADED);

    // MAC uses the weight held before the edge; clear overrides shift and the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= EMPTY;
            weight_out     <= '0;
            act_out        <= '0;
            act_valid_out  <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            err_no_weight  <= 1'b0;
            mac_count      <= '0;
        end else begin
            act_out        <= act_in;
            act_valid_out  <= act_valid_in;
            psum_valid_out <= 1'b0;

            if (act_valid_in) begin
                if (state == LOADED) begin
                    psum_out       <= mac_result;
                    psum_valid_out <= 1'b1;
                    if (mac_count != {CNT_W{1'b1}}) begin
                        mac_count <= mac_count + CNT_W'(1);
                    end
                end else begin
                    err_no_weight <= 1'b1;
                end
            end

            if (weight_clr) begin
                state      <= EMPTY;
                weight_out <= '0;
                mac_count  <= '0;
            end else if (weight_shift) begin
                state      <= LOADED;
                weight_out <= weight_in;
            end
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe: directed scenarios plus randomized traffic against a behavioural model.
module tb_systolic_pe;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int          CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] weight_in;
    logic          weight_shift;
    logic          weight_clr;
    logic [DW-1:0] weight_out;
    logic [DW-1:0] act_in;
    logic          act_valid_in;
    logic [DW-1:0] psum_in;
    logic [DW-1:0] act_out;
    logic          act_valid_out;
    logic [DW-1:0] psum_out;
    logic          psum_valid_out;
    logic          weight_loaded;
    logic          err_no_weight;
    logic [CW-1:0] mac_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_pe #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .weight_in      (weight_in),
        .weight_shift   (weight_shift),
        .weight_clr     (weight_clr),
        .weight_out     (weight_out),
        .act_in         (act_in),
        .act_valid_in   (act_valid_in),
        .psum_in        (psum_in),
        .act_out        (act_out),
        .act_valid_out  (act_valid_out),
        .psum_out       (psum_out),
        .psum_valid_out (psum_valid_out),
        .weight_loaded  (weight_loaded),
        .err_no_weight  (err_no_weight),
        .mac_count      (mac_count)
    );

    // Reference arithmetic: exact integer result, then clamp or wrap to DW bits.
    function automatic logic [DW-1:0] ref_mac(input logic [DW-1:0] a, input logic [DW-1:0] w,
                                              input logic [DW-1:0] p);
        longint s;
        s = longint'($signed(a)) * longint'($signed(w)) + longint'($signed(p));
`ifdef PE_SAT_EN
        if (s > 64'sd32767) s = 64'sd32767;
        else if (s < -64'sd32768) s = -64'sd32768;
`endif
        return s[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        weight_in    = '0;
        weight_shift = 1'b0;
        weight_clr   = 1'b0;
        act_in       = '0;
        act_valid_in = 1'b0;
        psum_in      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        checks++; if (weight_out !== '0) begin failures++; $display("FAIL reset.weight_out got %h exp 0", weight_out); end
        checks++; if (act_out !== '0) begin failures++; $display("FAIL reset.act_out got %h exp 0", act_out); end
        checks++; if (psum_out !== '0) begin failures++; $display("FAIL reset.psum_out got %h exp 0", psum_out); end
        checks++; if (act_valid_out !== 1'b0) begin failures++; $display("FAIL reset.act_valid_out got %b exp 0", act_valid_out); end
        checks++; if (psum_valid_out !== 1'b0) begin failures++; $display("FAIL reset.psum_valid_out got %b exp 0", psum_valid_out); end
        checks++; if (weight_loaded !== 1'b0) begin failures++; $display("FAIL reset.weight_loaded got %b exp 0", weight_loaded); end
        checks++; if (err_no_weight !== 1'b0) begin failures++; $display("FAIL reset.err_no_weight got %b exp 0", err_no_weight); end
        checks++; if (mac_count !== '0) begin failures++; $display("FAIL reset.mac_count got %0d exp 0", mac_count); end
    endtask

    task automatic test_basic_mac();
        weight_in = 16'd1; weight_shift = 1'b1;
        tick();
        weight_shift = 1'b0;
        checks++; if (weight_loaded !== 1'b1) begin failures++; $display("FAIL basic.weight_loaded got %b exp 1", weight_loaded); end
        checks++; if (weight_out !== 16'd1) begin failures++; $display("FAIL basic.weight_out got %h exp 0001", weight_out); end
        act_in = 16'd10; psum_in = 16'd5; act_valid_in = 1'b1;
        tick();
        act_valid_in = 1'b0;
        checks++; if (psum_out !== 16'd15) begin failures++; $display("FAIL basic.psum_out got %0d exp 15", psum_out); end
        checks++; if (act_out !== 16'd10) begin failures++; $display("FAIL basic.act_out got %0d exp 10", act_out); end
        checks++; if (act_valid_out !== 1'b1) begin failures++; $display("FAIL basic.act_valid_out got %b exp 1", act_valid_out); end
        checks++; if (psum_valid_out !== 1'b1) begin failures++; $display("FAIL basic.psum_valid_out got %b exp 1", psum_valid_out); end
        checks++; if (mac_count !== 4'd1) begin failures++; $display("FAIL basic.mac_count got %0d exp 1", mac_count); end
    endtask

    task automatic test_back_to_back();
        weight_in = 16'hFFFF; weight_shift = 1'b1;
        tick();
        weight_shift = 1'b0;
        act_in = 16'd20; psum_in = 16'd15; act_valid_in = 1'b1;
        tick();
        checks++; if (psum_out !== 16'hFFFB) begin failures++; $display("FAIL b2b.first_psum got %h exp fffb", psum_out); end
        checks++; if (psum_valid_out !== 1'b1) begin failures++; $display("FAIL b2b.first_valid got %b exp 1", psum_valid_out); end
        act_in = 16'hFFCE; psum_in = 16'd300;
        tick();
        act_valid_in = 1'b0;
        checks++; if (psum_out !== 16'd350) begin failures++; $display("FAIL b2b.second_psum got %0d exp 350", psum_out); end
        checks++; if (psum_valid_out !== 1'b1) begin failures++; $display("FAIL b2b.second_valid got %b exp 1", psum_valid_out); end
        checks++; if (mac_count !== 4'd3) begin failures++; $display("FAIL b2b.mac_count got %0d exp 3", mac_count); end
        tick();
        checks++; if (psum_valid_out !== 1'b0) begin failures++; $display("FAIL b2b.idle_valid got %b exp 0", psum_valid_out); end
        checks++; if (psum_out !== 16'd350) begin failures++; $display("FAIL b2b.idle_hold got %0d exp 350", psum_out); end
    endtask

    task automatic test_empty_err();
        weight_clr = 1'b1; weight_shift = 1'b1; weight_in = 16'd9;
        tick();
        weight_clr = 1'b0; weight_shift = 1'b0;
        checks++; if (weight_loaded !== 1'b0) begin failures++; $display("FAIL empty.clr_priority_loaded got %b exp 0", weight_loaded); end
        checks++; if (weight_out !== '0) begin failures++; $display("FAIL empty.clr_weight got %h exp 0", weight_out); end
        checks++; if (mac_count !== '0) begin failures++; $display("FAIL empty.clr_count got %0d exp 0", mac_count); end
        checks++; if (err_no_weight !== 1'b0) begin failures++; $display("FAIL empty.err_before got %b exp 0", err_no_weight); end
        act_in = 16'd7; psum_in = 16'd1; act_valid_in = 1'b1;
        tick();
        act_valid_in = 1'b0;
        checks++; if (psum_valid_out !== 1'b0) begin failures++; $display("FAIL empty.psum_valid got %b exp 0", psum_valid_out); end
        checks++; if (act_valid_out !== 1'b1) begin failures++; $display("FAIL empty.act_valid got %b exp 1", act_valid_out); end
        checks++; if (act_out !== 16'd7) begin failures++; $display("FAIL empty.act_out got %0d exp 7", act_out); end
        checks++; if (psum_out !== 16'd350) begin failures++; $display("FAIL empty.psum_hold got %0d exp 350", psum_out); end
        checks++; if (err_no_weight !== 1'b1) begin failures++; $display("FAIL empty.err_set got %b exp 1", err_no_weight); end
        weight_clr = 1'b1;
        tick();
        weight_clr = 1'b0;
        tick();
        checks++; if (err_no_weight !== 1'b1) begin failures++; $display("FAIL empty.err_sticky got %b exp 1", err_no_weight); end
    endtask

    task automatic test_shift_same_cycle();
        weight_in = 16'd1; weight_shift = 1'b1;
        tick();
        weight_in = 16'd3; act_in = 16'd10; psum_in = 16'd0; act_valid_in = 1'b1;
        tick();
        weight_shift = 1'b0;
        checks++; if (psum_out !== 16'd10) begin failures++; $display("FAIL same_cycle.old_weight got %0d exp 10", psum_out); end
        checks++; if (weight_out !== 16'd3) begin failures++; $display("FAIL same_cycle.weight_out got %0d exp 3", weight_out); end
        tick();
        act_valid_in = 1'b0;
        checks++; if (psum_out !== 16'd30) begin failures++; $display("FAIL same_cycle.new_weight got %0d exp 30", psum_out); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_pos;
        logic [DW-1:0] exp_neg;
`ifdef PE_SAT_EN
        exp_pos = 16'h7FFF;
        exp_neg = 16'h8000;
`else
        exp_pos = 16'h9C40;
        exp_neg = 16'h63C0;
`endif
        weight_in = 16'd2; weight_shift = 1'b1;
        tick();
        weight_shift = 1'b0;
        act_in = 16'd20000; psum_in = 16'd0; act_valid_in = 1'b1;
        tick();
        checks++; if (psum_out !== exp_pos) begin failures++; $display("FAIL overflow.pos got %h exp %h", psum_out, exp_pos); end
        act_in = 16'hB1E0;
        tick();
        act_valid_in = 1'b0;
        checks++; if (psum_out !== exp_neg) begin failures++; $display("FAIL overflow.neg got %h exp %h", psum_out, exp_neg); end
    endtask

    task automatic test_count_saturate();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        checks++; if (err_no_weight !== 1'b0) begin failures++; $display("FAIL count.err_cleared got %b exp 0", err_no_weight); end
        weight_in = 16'd1; weight_shift = 1'b1;
        tick();
        weight_shift = 1'b0;
        for (int i = 0; i < 20; i++) begin
            act_in = 16'd1; psum_in = DW'(i); act_valid_in = 1'b1;
            tick();
            checks++;
            if (mac_count !== CW'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1)) begin
                failures++;
                $display("FAIL count.step%0d got %0d exp %0d", i, mac_count, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
            end
        end
        act_valid_in = 1'b0;
        checks++; if (psum_out !== 16'd20) begin failures++; $display("FAIL count.last_psum got %0d exp 20", psum_out); end
    endtask

    task automatic test_reset_midstream();
        act_in = 16'd5; psum_in = 16'd1; act_valid_in = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; act_valid_in = 1'b0;
        checks++; if (psum_out !== '0) begin failures++; $display("FAIL rst_mid.psum_out got %h exp 0", psum_out); end
        checks++; if (psum_valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid.psum_valid got %b exp 0", psum_valid_out); end
        checks++; if (act_valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid.act_valid got %b exp 0", act_valid_out); end
        checks++; if (weight_loaded !== 1'b0) begin failures++; $display("FAIL rst_mid.loaded got %b exp 0", weight_loaded); end
        checks++; if (mac_count !== '0) begin failures++; $display("FAIL rst_mid.count got %0d exp 0", mac_count); end
    endtask

    // Behavioural model starts from the post-reset state left by the previous task.
    task automatic test_random();
        logic          m_loaded = 1'b0;
        logic [DW-1:0] m_w      = '0;
        logic [DW-1:0] m_psum   = '0;
        logic          m_err    = 1'b0;
        int            m_cnt    = 0;
        logic [DW-1:0] e_act;
        logic          e_av;
        logic          e_pv;
        for (int n = 0; n < 400; n++) begin
            weight_in    = DW'($urandom);
            weight_shift = ($urandom_range(0, 99) < 15);
            weight_clr   = ($urandom_range(0, 99) < 5);
            act_valid_in = ($urandom_range(0, 99) < 70);
            act_in       = DW'($urandom);
            psum_in      = DW'($urandom);
            e_act = act_in;
            e_av  = act_valid_in;
            e_pv  = 1'b0;
            if (act_valid_in) begin
                if (m_loaded) begin
                    m_psum = ref_mac(act_in, m_w, psum_in);
                    e_pv   = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (weight_clr) begin
                m_loaded = 1'b0; m_w = '0; m_cnt = 0;
            end else if (weight_shift) begin
                m_loaded = 1'b1; m_w = weight_in;
            end
            tick();
            checks++; if (psum_out !== m_psum) begin failures++; $display("FAIL rand%0d.psum_out got %h exp %h", n, psum_out, m_psum); end
            checks++; if (psum_valid_out !== e_pv) begin failures++; $display("FAIL rand%0d.psum_valid got %b exp %b", n, psum_valid_out, e_pv); end
            checks++; if (act_out !== e_act || act_valid_out !== e_av) begin failures++; $display("FAIL rand%0d.act got %h/%b exp %h/%b", n, act_out, act_valid_out, e_act, e_av); end
            checks++; if (weight_out !== m_w || weight_loaded !== m_loaded) begin failures++; $display("FAIL rand%0d.weight got %h/%b exp %h/%b", n, weight_out, weight_loaded, m_w, m_loaded); end
            checks++; if (mac_count !== CW'(m_cnt)) begin failures++; $display("FAIL rand%0d.mac_count got %0d exp %0d", n, mac_count, m_cnt); end
            checks++; if (err_no_weight !== m_err) begin failures++; $display("FAIL rand%0d.err got %b exp %b", n, err_no_weight, m_err); end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_mac();
        test_back_to_back();
        test_empty_err();
        test_shift_same_cycle();
        test_overflow();
        test_count_saturate();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Weight-stationary processing element for the NPU systolic array. Holds one signed weight loaded through a column shift chain. Computes `act_in * weight + psum_in` through the combinational `mac` datapath and registers the results. Forwards the activation east and the partial sum south, so cells tile directly into an N×N array fed by the input skew logic.

## Interface
Parameters:
- `DATA_W`, 16: width of activations, weights and partial sums (signed, two's complement).
- `CNT_W`, 16: width of the MAC operation counter.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `weight_in`  in  DATA_W  weight arriving from the cell to the north (column shift chain).
- `weight_shift`  in  1  load `weight_in` into the weight register this cycle.
- `weight_clr`  in  1  discard the held weight and return to EMPTY.
- `weight_out`  out  DATA_W  currently held weight, to the cell to the south.
- `act_in`  in  DATA_W  signed activation from the west.
- `act_valid_in`  in  1  `act_in` / `psum_in` valid this cycle.
- `psum_in`  in  DATA_W  signed partial sum from the north.
- `act_out`  out  DATA_W  registered `act_in`, to the east.
- `act_valid_out`  out  1  registered `act_valid_in`.
- `psum_out`  out  DATA_W  registered MAC result, to the south.
- `psum_valid_out`  out  1  `psum_out` valid.
- `weight_loaded`  out  1  high in LOADED state.
- `err_no_weight`  out  1  sticky: an activation arrived while EMPTY.
- `mac_count`  out  CNT_W  number of MACs performed since reset/clear.

## Operation
- State machine:
  - States: EMPTY (reset state) and LOADED.
  - EMPTY→LOADED on `weight_shift`.
  - LOADED→EMPTY on `weight_clr`.
  - `weight_clr` takes priority over `weight_shift` in the same cycle.
- Weight register:
  - Written with `weight_in` on every `weight_shift`, in either state, so it behaves as a shift chain.
  - `weight_out` is driven directly from the register.
  - Cleared to 0 on `weight_clr`.
- Activation forwarding: `act_out` and `act_valid_out` always register `act_in` and `act_valid_in`, regardless of state. The chain must never stall.
- MAC in LOADED with `act_valid_in`:
  - `psum_out <= act_in*weight + psum_in`.
  - `psum_valid_out <= 1`.
  - `mac_count` increments.
- MAC in EMPTY with `act_valid_in`:
  - `psum_valid_out <= 0` and `psum_out` holds.
  - `err_no_weight` sets. It clears only on `rst`.
- Cycles with `act_valid_in` low: `psum_valid_out <= 0` and `psum_out` holds its last value.
- Simultaneous `weight_shift` and `act_valid_in`: the MAC uses the weight held before the edge. The new weight applies from the next cycle.
- Arithmetic: the product is full-width (2·DATA_W), added to sign-extended `psum_in`, then reduced per Configuration.
- `mac_count`:
  - Saturates at all-ones; it does not wrap.
  - Resets to 0 on `rst` or `weight_clr`.

## Timing
- Reset values:
  - All outputs 0, including `weight_out`, `act_out`, `psum_out` and both valids.
  - `weight_loaded` 0, `err_no_weight` 0, `mac_count` 0.
  - State EMPTY.
- Latency: act_in/psum_in → act_out/psum_out is exactly 1 cycle. Throughput is one MAC per cycle, back-to-back.
- `weight_loaded` goes high the cycle after the first `weight_shift`.
- `rst` during streaming: the next edge zeroes every register. Data in flight is lost and no valid is emitted.

## Configuration
- Macro `PE_SAT_EN`.
- Defined: the result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: the result is truncated to its low DATA_W bits (modulo wrap), bit-exact with the `mac` block.

## Structure
- `npu_pkg` holds:
  - `DATA_W` default constant.
  - `pe_state_t` enum {EMPTY, LOADED}.
  - `sat_to_data_w` function used when `PE_SAT_EN` is defined.
- Sub-module: `mac` instantiated for the multiply-add datapath. When `PE_SAT_EN` is defined, the wide sum is computed in the PE and saturated before the register.

## Test plan
- Reset: assert `rst` 2 cycles → every output 0, `weight_loaded`=0.
- Shift weight 1; next cycle act=10, psum=5, valid → one cycle later psum_out=15, act_out=10, both valids 1, mac_count=1.
- Weight -1, act=20, psum=15 → psum_out=-5; then act=-50, psum=300 → psum_out=350 on the following cycle (back-to-back).
- Valid act while EMPTY → psum_valid_out=0, act_valid_out=1, err_no_weight=1 and stays 1.
- Weight 1 held, then `weight_shift` with weight_in=3 plus act=10, psum=0 in the same cycle → psum_out=10; the next act=10 gives 30.
- Overflow: weight 2, act=20000, psum=0 → with `PE_SAT_EN` 32767, without it -25536.
